// File: rtl/io_port_ctrl_if.sv
// CPU bus strobes and the TX/RX streaming handshakes of the I/O port controller.
// The shared data bus is a tri-state net and stays a plain inout on the controller.
// bus_oe shows when the controller is driving that bus.
interface io_port_if;
  logic [7:0] addr_bus;
  logic       mem_io;
  logic       c_ri;
  logic       c_ro;
  logic       mem_clk;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       irq;
  logic       bus_oe;

  // CPU / peripheral side
  modport master (
    output addr_bus, mem_io, c_ri, c_ro, mem_clk, tx_ready, rx_data, rx_valid,
    input  tx_data, tx_valid, rx_ready, irq, bus_oe
  );

  // Port controller side
  modport slave (
    input  addr_bus, mem_io, c_ri, c_ro, mem_clk, tx_ready, rx_data, rx_valid,
    output tx_data, tx_valid, rx_ready, irq, bus_oe
  );
endinterface

// File: rtl/io_port_ctrl.sv
// Memory-mapped I/O port controller: CPU OUT writes fill a TX FIFO that an external
// valid/ready consumer drains. External bytes fill an RX FIFO that the CPU reads.
// Address bit 0 selects the DATA port (0) or the STATUS port (1).
module io_port_ctrl #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic       clk,
  input  logic       reset,
  io_port_if.slave   io,
  inout  wire  [7:0] bus
);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // Access decode. When both strobes are high, the cycle is treated as no access.
  logic sel_io, wr_evt, rd_evt, sel_status;
  assign sel_io     = io.mem_io & (io.c_ri ^ io.c_ro);
  assign wr_evt     = sel_io & io.c_ri & io.mem_clk;
  assign rd_evt     = sel_io & io.c_ro & io.mem_clk;
  assign sel_status = io.addr_bus[0];

  // Only bit 0 of the address is decoded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^io.addr_bus[7:1];

  // FIFO state
  logic [7:0]       tx_mem_reg [DEPTH];
  logic [7:0]       rx_mem_reg [DEPTH];
  logic [PTR_W-1:0] tx_wr_ptr_reg, tx_wr_ptr_next, tx_rd_ptr_reg, tx_rd_ptr_next;
  logic [PTR_W-1:0] rx_wr_ptr_reg, rx_wr_ptr_next, rx_rd_ptr_reg, rx_rd_ptr_next;
  logic [PTR_W:0]   tx_count_reg, tx_count_next, rx_count_reg, rx_count_next;
  logic             ovf_reg, ovf_next;

  logic tx_full, tx_nonempty, rx_full, rx_nonempty;
  assign tx_full     = (tx_count_reg == CNT_FULL);
  assign tx_nonempty = (tx_count_reg != '0);
  assign rx_full     = (rx_count_reg == CNT_FULL);
  assign rx_nonempty = (rx_count_reg != '0);

  // Push/pop qualification. A DATA write into a full TX FIFO is dropped,
  // even when the consumer pops in the same cycle.
  logic tx_push_req, tx_push, tx_drop, tx_pop, rx_push, rx_pop, ovf_clr;
  assign tx_push_req = wr_evt & ~sel_status;
  assign tx_push     = tx_push_req & ~tx_full;
  assign tx_drop     = tx_push_req & tx_full;
  assign tx_pop      = tx_nonempty & io.tx_ready;
  assign rx_push     = io.rx_valid & ~rx_full;
  assign rx_pop      = rd_evt & ~sel_status & rx_nonempty;
  assign ovf_clr     = wr_evt & sel_status;

  // Per-entry write enables selected by the write pointers
  logic [DEPTH-1:0] tx_we, rx_we;
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_we
      assign tx_we[gi] = tx_push & (tx_wr_ptr_reg == PTR_W'(gi));
      assign rx_we[gi] = rx_push & (rx_wr_ptr_reg == PTR_W'(gi));
    end
  endgenerate

  // Next-state for pointers, counts and the sticky overflow flag
  always_comb begin
    tx_wr_ptr_next = tx_push ? tx_wr_ptr_reg + PTR_ONE : tx_wr_ptr_reg;
    tx_rd_ptr_next = tx_pop  ? tx_rd_ptr_reg + PTR_ONE : tx_rd_ptr_reg;
    rx_wr_ptr_next = rx_push ? rx_wr_ptr_reg + PTR_ONE : rx_wr_ptr_reg;
    rx_rd_ptr_next = rx_pop  ? rx_rd_ptr_reg + PTR_ONE : rx_rd_ptr_reg;
    tx_count_next  = tx_count_reg;
    rx_count_next  = rx_count_reg;
    if (tx_push && !tx_pop) tx_count_next = tx_count_reg + CNT_ONE;
    if (!tx_push && tx_pop) tx_count_next = tx_count_reg - CNT_ONE;
    if (rx_push && !rx_pop) rx_count_next = rx_count_reg + CNT_ONE;
    if (!rx_push && rx_pop) rx_count_next = rx_count_reg - CNT_ONE;
    ovf_next = ovf_reg;
    if (ovf_clr) ovf_next = 1'b0;
    if (tx_drop) ovf_next = 1'b1;
  end

  // Control registers. Reset has priority, so an access in the reset cycle is aborted.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wr_ptr_reg <= '0;
      tx_rd_ptr_reg <= '0;
      rx_wr_ptr_reg <= '0;
      rx_rd_ptr_reg <= '0;
      tx_count_reg  <= '0;
      rx_count_reg  <= '0;
      ovf_reg       <= 1'b0;
    end else begin
      tx_wr_ptr_reg <= tx_wr_ptr_next;
      tx_rd_ptr_reg <= tx_rd_ptr_next;
      rx_wr_ptr_reg <= rx_wr_ptr_next;
      rx_rd_ptr_reg <= rx_rd_ptr_next;
      tx_count_reg  <= tx_count_next;
      rx_count_reg  <= rx_count_next;
      ovf_reg       <= ovf_next;
    end
  end

  // Data storage. This is left without reset because the counts gate every read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!reset && tx_we[i]) tx_mem_reg[i] <= bus;
      if (!reset && rx_we[i]) rx_mem_reg[i] <= io.rx_data;
    end
  end

  // Streaming outputs. The TX head falls through, and the IRQ is a level signal.
  assign io.tx_valid = tx_nonempty;
  assign io.tx_data  = tx_nonempty ? tx_mem_reg[tx_rd_ptr_reg] : 8'h00;
  assign io.rx_ready = ~rx_full;
  assign io.irq      = rx_nonempty | ovf_reg;

  // CPU read data. It comes only from registered state, so it holds steady for the whole strobe.
  logic [7:0] status_byte, rd_data;
  assign status_byte = {4'b0000, ovf_reg, rx_full, rx_nonempty, tx_full};
  assign rd_data     = sel_status ? status_byte
                     : (rx_nonempty ? rx_mem_reg[rx_rd_ptr_reg] : 8'h00);

  // The bus is driven for the whole read strobe. It is released at once when reset is asserted.
  assign io.bus_oe = sel_io & io.c_ro & ~reset;
  assign bus       = io.bus_oe ? rd_data : 8'hzz;
endmodule
